// File: rtl/fetch_stage.sv
// Pipeline front end: owns the PC, reads instruction memory and hands registered
// instructions (including assembled two-word forms and interrupt bubbles) to decode.
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] INT_VECTOR = 16'h0020,
  parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  input  logic        i_interrupt,
  output logic [15:0] o_imem_addr,
  input  logic [15:0] i_imem_data,
  output logic [15:0] o_instr,
  output logic [15:0] o_imm,
  output logic [15:0] o_pc,
  output logic        o_valid,
  output logic        o_interrupt
);

  typedef enum logic {
    FETCH = 1'b0,
    IMM   = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic [15:0] held_word, held_word_nxt;
  logic [15:0] held_pc, held_pc_nxt;
  logic        int_pending, int_pending_nxt;
  logic [15:0] instr_nxt, imm_nxt, out_pc_nxt;
  logic        valid_nxt, intr_nxt;

  assign o_imem_addr = pc;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed by the combinational block below.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      held_word   <= 16'h0000;
      held_pc     <= 16'h0000;
      int_pending <= 1'b0;
      o_instr     <= NOP_INSTR;
      o_imm       <= 16'h0000;
      o_pc        <= 16'h0000;
      o_valid     <= 1'b0;
      o_interrupt <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      held_word   <= held_word_nxt;
      held_pc     <= held_pc_nxt;
      int_pending <= int_pending_nxt;
      o_instr     <= instr_nxt;
      o_imm       <= imm_nxt;
      o_pc        <= out_pc_nxt;
      o_valid     <= valid_nxt;
      o_interrupt <= intr_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    state_nxt       = state;
    pc_nxt          = pc;
    held_word_nxt   = held_word;
    held_pc_nxt     = held_pc;
    int_pending_nxt = int_pending | i_interrupt;
    instr_nxt       = o_instr;
    imm_nxt         = o_imm;
    out_pc_nxt      = o_pc;
    valid_nxt       = o_valid;
    intr_nxt        = o_interrupt;

    if (i_redirect) begin
      pc_nxt    = i_redirect_pc;
      state_nxt = FETCH;
      instr_nxt = NOP_INSTR;
      imm_nxt   = 16'h0000;
      valid_nxt = 1'b0;
      intr_nxt  = 1'b0;
    end else if (!i_stall) begin
      unique case (state)
        FETCH: begin
          if (int_pending) begin
            // Bubble carries the un-consumed pc as the return address.
            instr_nxt       = NOP_INSTR;
            imm_nxt         = 16'h0000;
            out_pc_nxt      = pc;
            valid_nxt       = 1'b1;
            intr_nxt        = 1'b1;
            pc_nxt          = INT_VECTOR;
            int_pending_nxt = 1'b0;
          end else if (!i_imem_data[0]) begin
            instr_nxt  = i_imem_data;
            imm_nxt    = 16'h0000;
            out_pc_nxt = pc;
            valid_nxt  = 1'b1;
            intr_nxt   = 1'b0;
            pc_nxt     = pc + 16'd1;
          end else begin
            held_word_nxt = i_imem_data;
            held_pc_nxt   = pc;
            pc_nxt        = pc + 16'd1;
            state_nxt     = IMM;
            instr_nxt     = NOP_INSTR;
            imm_nxt       = 16'h0000;
            valid_nxt     = 1'b0;
            intr_nxt      = 1'b0;
          end
        end
        IMM: begin
          instr_nxt  = held_word;
          imm_nxt    = i_imem_data;
          out_pc_nxt = held_pc;
          valid_nxt  = 1'b1;
          intr_nxt   = 1'b0;
          pc_nxt     = pc + 16'd1;
          state_nxt  = FETCH;
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

endmodule
